// File: rtl/axi_decerr_slave.sv
// Fall-through AXI slave: completes every unmapped transaction with DECERR
// and keeps debug-visible error statistics (count, last address, direction).
module axi_decerr_slave #(
   parameter int unsigned          IdWidth   = 5,
   parameter int unsigned          AddrWidth = 64,
   parameter int unsigned          DataWidth = 64,
   parameter int unsigned          CntWidth  = 16,
   parameter logic [DataWidth-1:0] RespData  = 64'hDEAD_BEEF_DEAD_BEEF
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 aw_valid_i,
   output logic                 aw_ready_o,
   input  logic [IdWidth-1:0]   aw_id_i,
   input  logic [AddrWidth-1:0] aw_addr_i,
   input  logic [7:0]           aw_len_i,
   input  logic                 w_valid_i,
   output logic                 w_ready_o,
   input  logic                 w_last_i,
   output logic                 b_valid_o,
   input  logic                 b_ready_i,
   output logic [IdWidth-1:0]   b_id_o,
   output logic [1:0]           b_resp_o,
   input  logic                 ar_valid_i,
   output logic                 ar_ready_o,
   input  logic [IdWidth-1:0]   ar_id_i,
   input  logic [AddrWidth-1:0] ar_addr_i,
   input  logic [7:0]           ar_len_i,
   output logic                 r_valid_o,
   input  logic                 r_ready_i,
   output logic [IdWidth-1:0]   r_id_o,
   output logic [DataWidth-1:0] r_data_o,
   output logic [1:0]           r_resp_o,
   output logic                 r_last_o,
   output logic [CntWidth-1:0]  err_cnt_o,
   output logic [AddrWidth-1:0] err_addr_o,
   output logic                 err_is_write_o
);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
   typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

   localparam logic [CntWidth-1:0] CntMax = '1;

   wstate_e    w_q, w_nxt;
   rstate_e    r_q, r_nxt;
   logic [7:0] beat_q;
   logic       aw_hs, ar_hs;
   logic [1:0] inc;
   logic [CntWidth:0] cnt_sum;

   // Burst length is irrelevant on the write side: w_last_i alone ends it.
   logic unused_aw_len;
   assign unused_aw_len = ^aw_len_i;

   assign b_resp_o = 2'b11;
   assign r_resp_o = 2'b11;
   assign r_data_o = RespData;

   assign aw_hs = aw_valid_i && aw_ready_o;
   assign ar_hs = ar_valid_i && ar_ready_o;

   always_comb begin
      w_nxt      = w_q;
      aw_ready_o = 1'b0;
      w_ready_o  = 1'b0;
      b_valid_o  = 1'b0;
      case (w_q)
         W_IDLE: begin
            aw_ready_o = 1'b1;
            if (aw_valid_i) w_nxt = W_DATA;
         end
         W_DATA: begin
            w_ready_o = 1'b1;
            if (w_valid_i && w_last_i) w_nxt = W_RESP;
         end
         W_RESP: begin
            b_valid_o = 1'b1;
            if (b_ready_i) w_nxt = W_IDLE;
         end
         default: w_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      r_nxt      = r_q;
      ar_ready_o = 1'b0;
      r_valid_o  = 1'b0;
      r_last_o   = 1'b0;
      case (r_q)
         R_IDLE: begin
            ar_ready_o = 1'b1;
            if (ar_valid_i) r_nxt = R_DATA;
         end
         R_DATA: begin
            r_valid_o = 1'b1;
            r_last_o  = (beat_q == 8'd0);
            if (r_ready_i && beat_q == 8'd0) r_nxt = R_IDLE;
         end
         default: r_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         w_q    <= W_IDLE;
         r_q    <= R_IDLE;
         b_id_o <= '0;
         r_id_o <= '0;
         beat_q <= '0;
      end else begin
         w_q <= w_nxt;
         r_q <= r_nxt;
         if (aw_hs) b_id_o <= aw_id_i;
         if (ar_hs) begin
            r_id_o <= ar_id_i;
            beat_q <= ar_len_i;
         end else if (r_valid_o && r_ready_i && beat_q != 8'd0) begin
            beat_q <= beat_q - 8'd1;
         end
      end
   end

   // Saturating counter; the wide sum lets the +2 case clamp cleanly.
   assign inc     = {1'b0, aw_hs} + {1'b0, ar_hs};
   assign cnt_sum = {1'b0, err_cnt_o} + {{(CntWidth-1){1'b0}}, inc};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_cnt_o      <= '0;
         err_addr_o     <= '0;
         err_is_write_o <= 1'b0;
      end else begin
         if (aw_hs || ar_hs)
            err_cnt_o <= (cnt_sum > {1'b0, CntMax}) ? CntMax : cnt_sum[CntWidth-1:0];
         if (aw_hs) begin
            err_addr_o     <= aw_addr_i;
            err_is_write_o <= 1'b1;
         end else if (ar_hs) begin
            err_addr_o     <= ar_addr_i;
            err_is_write_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi_decerr_slave.sv
// Directed bench for axi_decerr_slave; a second instance with a 4-bit
// counter shares all inputs to exercise counter saturation.
module tb_axi_decerr_slave;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        aw_valid_i, w_valid_i, w_last_i, b_ready_i, ar_valid_i, r_ready_i;
   logic [4:0]  aw_id_i, ar_id_i;
   logic [63:0] aw_addr_i, ar_addr_i;
   logic [7:0]  aw_len_i, ar_len_i;

   logic        aw_ready_o, w_ready_o, b_valid_o, ar_ready_o, r_valid_o, r_last_o, err_is_write_o;
   logic [4:0]  b_id_o, r_id_o;
   logic [1:0]  b_resp_o, r_resp_o;
   logic [63:0] r_data_o, err_addr_o;
   logic [15:0] err_cnt_o;

   logic        s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_valid, s_r_last, s_is_write;
   logic [4:0]  s_b_id, s_r_id;
   logic [1:0]  s_b_resp, s_r_resp;
   logic [63:0] s_r_data, s_err_addr;
   logic [3:0]  s_err_cnt;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   axi_decerr_slave dut (
      .clk_i, .rst_ni,
      .aw_valid_i, .aw_ready_o, .aw_id_i, .aw_addr_i, .aw_len_i,
      .w_valid_i, .w_ready_o, .w_last_i,
      .b_valid_o, .b_ready_i, .b_id_o, .b_resp_o,
      .ar_valid_i, .ar_ready_o, .ar_id_i, .ar_addr_i, .ar_len_i,
      .r_valid_o, .r_ready_i, .r_id_o, .r_data_o, .r_resp_o, .r_last_o,
      .err_cnt_o, .err_addr_o, .err_is_write_o
   );

   axi_decerr_slave #(.CntWidth(4)) dut_sat (
      .clk_i, .rst_ni,
      .aw_valid_i, .aw_ready_o(s_aw_ready), .aw_id_i, .aw_addr_i, .aw_len_i,
      .w_valid_i, .w_ready_o(s_w_ready), .w_last_i,
      .b_valid_o(s_b_valid), .b_ready_i, .b_id_o(s_b_id), .b_resp_o(s_b_resp),
      .ar_valid_i, .ar_ready_o(s_ar_ready), .ar_id_i, .ar_addr_i, .ar_len_i,
      .r_valid_o(s_r_valid), .r_ready_i, .r_id_o(s_r_id), .r_data_o(s_r_data),
      .r_resp_o(s_r_resp), .r_last_o(s_r_last),
      .err_cnt_o(s_err_cnt), .err_addr_o(s_err_addr), .err_is_write_o(s_is_write)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   // One len=0 read, completed with r_ready held high.
   task automatic single_read(input logic [63:0] addr);
      ar_valid_i = 1'b1; ar_id_i = 5'h0A; ar_addr_i = addr; ar_len_i = 8'd0;
      cyc();
      ar_valid_i = 1'b0; r_ready_i = 1'b1;
      check("sr_last", 64'(r_last_o), 64'd1);
      cyc();
      r_ready_i = 1'b0;
      check("sr_done", 64'(r_valid_o), 64'd0);
   endtask

   initial begin
      int beats, bad, expc;
      logic rr;
      rst_ni = 1'b0;
      aw_valid_i = 0; w_valid_i = 0; w_last_i = 0; b_ready_i = 0; ar_valid_i = 0; r_ready_i = 0;
      aw_id_i = '0; ar_id_i = '0; aw_addr_i = '0; ar_addr_i = '0; aw_len_i = '0; ar_len_i = '0;

      // reset state
      @(negedge clk_i);
      check("rst_aw_ready", 64'(aw_ready_o), 64'd1);
      check("rst_ar_ready", 64'(ar_ready_o), 64'd1);
      check("rst_w_ready",  64'(w_ready_o), 64'd0);
      check("rst_b_valid",  64'(b_valid_o), 64'd0);
      check("rst_r_valid",  64'(r_valid_o), 64'd0);
      check("rst_r_last",   64'(r_last_o), 64'd0);
      check("rst_ids",      64'({b_id_o, r_id_o}), 64'd0);
      check("rst_cnt",      64'(err_cnt_o), 64'd0);
      check("rst_addr",     err_addr_o, 64'd0);
      check("rst_is_write", 64'(err_is_write_o), 64'd0);
      check("resp_consts",  64'({b_resp_o, r_resp_o}), 64'hF);
      check("r_data_const", r_data_o, 64'hDEAD_BEEF_DEAD_BEEF);
      rst_ni = 1'b1;
      cyc();

      // single write with B back-pressure
      aw_valid_i = 1; aw_id_i = 5'h13; aw_addr_i = 64'h5000_0000; aw_len_i = 0;
      cyc();
      aw_valid_i = 0;
      check("wr_aw_ready", 64'(aw_ready_o), 64'd0);
      check("wr_w_ready",  64'(w_ready_o), 64'd1);
      check("wr_cnt",      64'(err_cnt_o), 64'd1);
      check("wr_addr",     err_addr_o, 64'h5000_0000);
      check("wr_is_write", 64'(err_is_write_o), 64'd1);
      w_valid_i = 1; w_last_i = 1;
      cyc();
      w_valid_i = 0; w_last_i = 0;
      for (int i = 0; i < 3; i++) begin
         check("wr_b_hold", 64'({b_valid_o, b_id_o, b_resp_o}), 64'({1'b1, 5'h13, 2'b11}));
         cyc();
      end
      b_ready_i = 1;
      check("wr_b_valid", 64'(b_valid_o), 64'd1);
      cyc();
      b_ready_i = 0;
      check("wr_b_done", 64'(b_valid_o), 64'd0);
      check("wr_idle",   64'(aw_ready_o), 64'd1);

      // read burst len=3 with r_ready toggling
      ar_valid_i = 1; ar_id_i = 5'h07; ar_addr_i = 64'h5000_1000; ar_len_i = 8'd3;
      cyc();
      ar_valid_i = 0;
      check("rd_cnt",      64'(err_cnt_o), 64'd2);
      check("rd_is_write", 64'(err_is_write_o), 64'd0);
      check("rd_addr",     err_addr_o, 64'h5000_1000);
      beats = 0; rr = 1'b1;
      for (int c = 0; c < 40 && beats < 4; c++) begin
         r_ready_i = rr;
         check("rd_valid", 64'(r_valid_o), 64'd1);
         check("rd_last",  64'(r_last_o), 64'(beats == 3));
         check("rd_beat",  64'({r_id_o, r_resp_o}), 64'({5'h07, 2'b11}));
         check("rd_data",  r_data_o, 64'hDEAD_BEEF_DEAD_BEEF);
         if (rr) beats++;
         rr = ~rr;
         cyc();
      end
      r_ready_i = 0;
      check("rd_beats", 64'(beats), 64'd4);
      check("rd_end",   64'(r_valid_o), 64'd0);

      // simultaneous AW/AR, two-beat write
      aw_valid_i = 1; aw_id_i = 5'h01; aw_addr_i = 64'h6000_0000;
      ar_valid_i = 1; ar_id_i = 5'h02; ar_addr_i = 64'h7000_0000; ar_len_i = 0;
      cyc();
      aw_valid_i = 0; ar_valid_i = 0;
      check("sim_cnt",      64'(err_cnt_o), 64'd4);
      check("sim_addr",     err_addr_o, 64'h6000_0000);
      check("sim_is_write", 64'(err_is_write_o), 64'd1);
      check("sim_r", 64'({r_valid_o, r_last_o, r_id_o}), 64'({2'b11, 5'h02}));
      w_valid_i = 1; w_last_i = 0; r_ready_i = 1;
      cyc();
      w_last_i = 1; r_ready_i = 0;
      check("sim_r_done",  64'(r_valid_o), 64'd0);
      check("sim_w_first", 64'({w_ready_o, b_valid_o}), 64'b10);
      cyc();
      w_valid_i = 0; w_last_i = 0; b_ready_i = 1;
      check("sim_b", 64'({b_valid_o, b_id_o}), 64'({1'b1, 5'h01}));
      cyc();
      b_ready_i = 0;
      check("sim_b_done", 64'(b_valid_o), 64'd0);

      // AR back-pressure behind a 256-beat read
      ar_valid_i = 1; ar_id_i = 5'h03; ar_addr_i = 64'h5000_2000; ar_len_i = 8'd255;
      cyc();
      ar_id_i = 5'h04; ar_addr_i = 64'h5000_3000; ar_len_i = 0; r_ready_i = 1;
      check("bp_cnt", 64'(err_cnt_o), 64'd5);
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         if (ar_ready_o !== 1'b0 || r_valid_o !== 1'b1 || r_last_o !== (i == 255) || r_id_o !== 5'h03)
            bad++;
         cyc();
      end
      check("bp_stall",  64'(bad), 64'd0);
      check("bp_accept", 64'({ar_ready_o, r_valid_o}), 64'b10);
      check("bp_cnt_hold", 64'(err_cnt_o), 64'd5);
      cyc();
      ar_valid_i = 0;
      check("bp_r2",   64'({r_valid_o, r_last_o, r_id_o}), 64'({2'b11, 5'h04}));
      check("bp_cnt2", 64'(err_cnt_o), 64'd6);
      check("bp_addr", err_addr_o, 64'h5000_3000);
      cyc();
      r_ready_i = 0;
      check("bp_done", 64'(r_valid_o), 64'd0);

      // saturation: 4-bit instance clamps at 15, including the +2 case
      check("sat_track", 64'(s_err_cnt), 64'd6);
      expc = 6;
      for (int i = 0; i < 8; i++) begin
         single_read(64'h5100_0000 + 64'(i));
         expc++;
         check("sat_cnt16", 64'(err_cnt_o), 64'(expc));
      end
      check("sat_pre", 64'(s_err_cnt), 64'd14);
      aw_valid_i = 1; aw_id_i = 5'h05; aw_addr_i = 64'h5200_0000;
      ar_valid_i = 1; ar_id_i = 5'h06; ar_addr_i = 64'h5300_0000; ar_len_i = 0;
      cyc();
      aw_valid_i = 0; ar_valid_i = 0;
      check("sat_plus2_16", 64'(err_cnt_o), 64'd16);
      check("sat_plus2_4",  64'(s_err_cnt), 64'd15);
      w_valid_i = 1; w_last_i = 1; r_ready_i = 1;
      cyc();
      w_valid_i = 0; w_last_i = 0; r_ready_i = 0; b_ready_i = 1;
      cyc();
      b_ready_i = 0;
      single_read(64'h5400_0000);
      check("sat_17_16", 64'(err_cnt_o), 64'd17);
      check("sat_17_4",  64'(s_err_cnt), 64'd15);

      // reset in the middle of a len=7 read
      ar_valid_i = 1; ar_id_i = 5'h09; ar_addr_i = 64'h5500_0000; ar_len_i = 8'd7;
      cyc();
      ar_valid_i = 0; r_ready_i = 1;
      cyc();
      check("mid_beat2", 64'({r_valid_o, r_last_o}), 64'b10);
      #2 rst_ni = 1'b0;
      #1;
      check("mid_r_valid", 64'(r_valid_o), 64'd0);
      check("mid_outs", 64'({r_last_o, r_id_o, b_id_o, err_is_write_o}), 64'd0);
      check("mid_cnt",  64'(err_cnt_o), 64'd0);
      check("mid_addr", err_addr_o, 64'd0);
      check("mid_ready", 64'({aw_ready_o, ar_ready_o, w_ready_o, b_valid_o}), 64'b1100);
      @(negedge clk_i);
      rst_ni = 1'b1;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         if (r_valid_o !== 1'b0) bad++;
      end
      check("mid_no_residual", 64'(bad), 64'd0);
      ar_valid_i = 1; ar_id_i = 5'h1F; ar_addr_i = 64'h5600_0000; ar_len_i = 8'd1;
      cyc();
      ar_valid_i = 0;
      check("post_b1", 64'({r_valid_o, r_last_o, r_id_o}), 64'({2'b10, 5'h1F}));
      check("post_cnt", 64'(err_cnt_o), 64'd1);
      cyc();
      check("post_b2", 64'({r_valid_o, r_last_o}), 64'b11);
      cyc();
      r_ready_i = 0;
      check("post_done", 64'(r_valid_o), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
